// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard controller bundle: ID-stage instruction fields, EX/MEM status in, stage controls out.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned REG_W = 4
) ();
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_src2_en;
  logic             id_wb_en;
  logic [REG_W-1:0] id_dest;
  logic             id_mem_rd;
  logic             id_mem_wr;
  logic             branch_taken;
  logic             mem_ready;
  logic             freez;
  logic             id_ex_bubble;
  logic             flush;
  logic             pipe_hold;
  logic             mem_timeout;
  logic [15:0]      stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_src2_en, id_wb_en, id_dest,
    output id_mem_rd, id_mem_wr, branch_taken, mem_ready,
    input  freez, id_ex_bubble, flush, pipe_hold, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_src2_en, id_wb_en, id_dest,
    input  id_mem_rd, id_mem_wr, branch_taken, mem_ready,
    output freez, id_ex_bubble, flush, pipe_hold, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// RAW-hazard stall, wrong-path squash and data-memory freeze for the 5-stage pipe.
// Controls are combinational and act at the next edge; a memory wait holds every stage indefinitely.
module hazard_ctrl #(
  parameter int unsigned REG_W       = 4,
  parameter bit          FWD_EN      = 1'b0,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;

  typedef struct packed {
    logic             valid;
    logic             wb;
    logic [REG_W-1:0] dest;
    logic             load;
    logic             mem;
  } sb_entry_t;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  sb_entry_t        sb_ex_q, sb_ex_d;
  sb_entry_t        sb_mem_q, sb_mem_d;
  sb_entry_t        id_entry;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W:0]   cnt_inc;
  logic             mem_timeout_q, mem_timeout_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  logic ex_hit, mem_hit, hazard, mwait;
  logic freez_c, bubble_c, flush_c, hold_c;

  function automatic logic src_hit(input sb_entry_t e, input logic [REG_W-1:0] src,
                                   input logic need_load);
    return e.valid && e.wb && (e.dest == src) && (!need_load || e.load);
  endfunction

  // With forwarding only a load still sitting in EX cannot supply its result in time.
  always_comb begin
    ex_hit  = src_hit(sb_ex_q, hz.id_src1, FWD_EN)
            | (hz.id_src2_en & src_hit(sb_ex_q, hz.id_src2, FWD_EN));
    mem_hit = src_hit(sb_mem_q, hz.id_src1, 1'b0)
            | (hz.id_src2_en & src_hit(sb_mem_q, hz.id_src2, 1'b0));
    hazard  = hz.id_valid & (ex_hit | (!FWD_EN & mem_hit));
    mwait   = sb_mem_q.valid & sb_mem_q.mem & !hz.mem_ready;
  end

  always_comb begin
    freez_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    hold_c   = 1'b0;
    state_d  = RUN;
    if (mwait) begin
      hold_c  = 1'b1;
      freez_c = 1'b1;
      state_d = MEM_WAIT;
    end else if (hz.branch_taken) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
    end else if (hazard) begin
      freez_c  = 1'b1;
      bubble_c = 1'b1;
    end
  end

  always_comb begin
    id_entry.valid = 1'b1;
    id_entry.wb    = hz.id_wb_en;
    id_entry.dest  = hz.id_dest;
    id_entry.load  = hz.id_mem_rd;
    id_entry.mem   = hz.id_mem_rd | hz.id_mem_wr;

    sb_ex_d  = sb_ex_q;
    sb_mem_d = sb_mem_q;
    if (!hold_c) begin
      sb_mem_d = sb_ex_q;
      sb_ex_d  = (hz.id_valid && !bubble_c) ? id_entry : '0;
    end
  end

  // A fresh wait restarts the count; it saturates rather than wrapping.
  always_comb begin
    cnt_base      = (state_q == MEM_WAIT) ? wait_cnt_q : '0;
    cnt_inc       = {1'b0, cnt_base} + (CNT_W+1)'(1);
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (mwait) begin
      wait_cnt_d = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];
      if (cnt_inc >= (CNT_W+1)'(MEM_TIMEOUT)) begin
        mem_timeout_d = 1'b1;
      end
    end
    stall_cnt_d = stall_cnt_q;
    if (freez_c && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_ex_q       <= '0;
      sb_mem_q      <= '0;
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      sb_ex_q       <= sb_ex_d;
      sb_mem_q      <= sb_mem_d;
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign hz.freez        = rst & freez_c;
  assign hz.id_ex_bubble = rst & bubble_c;
  assign hz.flush        = rst & flush_c;
  assign hz.pipe_hold    = rst & hold_c;
  assign hz.mem_timeout  = mem_timeout_q;
  assign hz.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: one non-forwarding DUT (timeout 4) and one forwarding DUT share the same stimulus.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid, id_src2_en, id_wb_en, id_mem_rd, id_mem_wr, branch_taken, mem_ready;
  logic [3:0] id_src1, id_src2, id_dest;
  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] C_NONE  = 4'b0000;  // {freez, bubble, flush, pipe_hold}
  localparam logic [3:0] C_STALL = 4'b1100;
  localparam logic [3:0] C_BR    = 4'b0110;
  localparam logic [3:0] C_HOLD  = 4'b1001;

  hazard_ctrl_if #(.REG_W(4)) if_nf ();
  hazard_ctrl_if #(.REG_W(4)) if_fw ();

  assign if_nf.id_valid = id_valid;     assign if_fw.id_valid = id_valid;
  assign if_nf.id_src1 = id_src1;       assign if_fw.id_src1 = id_src1;
  assign if_nf.id_src2 = id_src2;       assign if_fw.id_src2 = id_src2;
  assign if_nf.id_src2_en = id_src2_en; assign if_fw.id_src2_en = id_src2_en;
  assign if_nf.id_wb_en = id_wb_en;     assign if_fw.id_wb_en = id_wb_en;
  assign if_nf.id_dest = id_dest;       assign if_fw.id_dest = id_dest;
  assign if_nf.id_mem_rd = id_mem_rd;   assign if_fw.id_mem_rd = id_mem_rd;
  assign if_nf.id_mem_wr = id_mem_wr;   assign if_fw.id_mem_wr = id_mem_wr;
  assign if_nf.branch_taken = branch_taken; assign if_fw.branch_taken = branch_taken;
  assign if_nf.mem_ready = mem_ready;   assign if_fw.mem_ready = mem_ready;

  hazard_ctrl #(.REG_W(4), .FWD_EN(1'b0), .MEM_TIMEOUT(4)) u_nf (.clk(clk), .rst(rst), .hz(if_nf));
  hazard_ctrl #(.REG_W(4), .FWD_EN(1'b1), .MEM_TIMEOUT(255)) u_fw (.clk(clk), .rst(rst), .hz(if_fw));

  wire [3:0] ctl_nf = {if_nf.freez, if_nf.id_ex_bubble, if_nf.flush, if_nf.pipe_hold};
  wire [3:0] ctl_fw = {if_fw.freez, if_fw.id_ex_bubble, if_fw.flush, if_fw.pipe_hold};

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2, input logic s2e,
                        input logic wb, input logic [3:0] d, input logic rd, input logic wr);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_src2_en = s2e;
    id_wb_en = wb; id_dest = d; id_mem_rd = rd; id_mem_wr = wr;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0; idle(); branch_taken = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; branch_taken = 1'b1; mem_ready = 1'b0;
    set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0);
    #1;
    checks++; if (ctl_nf !== C_NONE) begin failures++; $display("FAIL reset_ctl_nf got=%b exp=%b", ctl_nf, C_NONE); end
    checks++; if (ctl_fw !== C_NONE) begin failures++; $display("FAIL reset_ctl_fw got=%b exp=%b", ctl_fw, C_NONE); end
    checks++; if (if_nf.stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", if_nf.stall_cnt); end
    checks++; if (if_nf.mem_timeout !== 1'b0) begin failures++; $display("FAIL reset_mem_timeout got=%b exp=0", if_nf.mem_timeout); end
    @(negedge clk);
    checks++; if (ctl_nf !== C_NONE) begin failures++; $display("FAIL reset_held_ctl got=%b exp=%b", ctl_nf, C_NONE); end
    rst = 1'b1; idle(); branch_taken = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_raw_stall();
    do_reset();
    set_id(1, 4'd1, 4'd2, 1, 1, 4'd3, 0, 0); #1;
    checks++; if (ctl_nf !== C_NONE) begin failures++; $display("FAIL raw_add_issue got=%b exp=%b", ctl_nf, C_NONE); end
    @(negedge clk);
    set_id(1, 4'd3, 4'd1, 1, 1, 4'd5, 0, 0); #1;
    checks++; if (ctl_nf !== C_STALL) begin failures++; $display("FAIL raw_c1 got=%b exp=%b", ctl_nf, C_STALL); end
    checks++; if (ctl_fw !== C_NONE) begin failures++; $display("FAIL raw_fw_nonload got=%b exp=%b", ctl_fw, C_NONE); end
    @(negedge clk); #1;
    checks++; if (ctl_nf !== C_STALL) begin failures++; $display("FAIL raw_c2 got=%b exp=%b", ctl_nf, C_STALL); end
    @(negedge clk); #1;
    checks++; if (ctl_nf !== C_NONE) begin failures++; $display("FAIL raw_c3_issue got=%b exp=%b", ctl_nf, C_NONE); end
    @(negedge clk); idle(); #1;
    checks++; if (if_nf.stall_cnt !== 16'd2) begin failures++; $display("FAIL raw_stall_cnt got=%0d exp=2", if_nf.stall_cnt); end
    @(negedge clk);
    set_id(1, 4'd1, 4'd2, 1, 1, 4'd3, 0, 0); @(negedge clk);
    set_id(1, 4'd7, 4'd8, 1, 1, 4'd9, 0, 0); @(negedge clk);
    set_id(1, 4'd3, 4'd1, 1, 1, 4'd5, 0, 0); #1;
    checks++; if (ctl_nf !== C_STALL) begin failures++; $display("FAIL raw_gap1_stall got=%b exp=%b", ctl_nf, C_STALL); end
    @(negedge clk); #1;
    checks++; if (ctl_nf !== C_NONE) begin failures++; $display("FAIL raw_gap1_issue got=%b exp=%b", ctl_nf, C_NONE); end
    @(negedge clk); idle(); #1;
    checks++; if (if_nf.stall_cnt !== 16'd3) begin failures++; $display("FAIL raw_gap1_cnt got=%0d exp=3", if_nf.stall_cnt); end
    @(negedge clk);
  endtask

  task automatic test_load_use_fw();
    do_reset();
    set_id(1, 4'd1, 4'd0, 0, 1, 4'd2, 1, 0); #1;
    checks++; if (ctl_fw !== C_NONE) begin failures++; $display("FAIL lu_ldr_issue got=%b exp=%b", ctl_fw, C_NONE); end
    @(negedge clk);
    set_id(1, 4'd2, 4'd2, 1, 1, 4'd4, 0, 0); #1;
    checks++; if (ctl_fw !== C_STALL) begin failures++; $display("FAIL lu_stall got=%b exp=%b", ctl_fw, C_STALL); end
    @(negedge clk); #1;
    checks++; if (ctl_fw !== C_NONE) begin failures++; $display("FAIL lu_issue got=%b exp=%b", ctl_fw, C_NONE); end
    @(negedge clk); idle(); #1;
    checks++; if (if_fw.stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", if_fw.stall_cnt); end
    @(negedge clk);
    set_id(1, 4'd1, 4'd3, 1, 1, 4'd2, 0, 0); @(negedge clk);
    set_id(1, 4'd2, 4'd2, 1, 1, 4'd4, 0, 0); #1;
    checks++; if (ctl_fw !== C_NONE) begin failures++; $display("FAIL alu_fwd_nostall got=%b exp=%b", ctl_fw, C_NONE); end
    checks++; if (ctl_nf !== C_STALL) begin failures++; $display("FAIL alu_nf_stall got=%b exp=%b", ctl_nf, C_STALL); end
    @(negedge clk); idle(); #1;
    checks++; if (if_fw.stall_cnt !== 16'd1) begin failures++; $display("FAIL alu_fwd_cnt got=%0d exp=1", if_fw.stall_cnt); end
    @(negedge clk);
  endtask

  task automatic test_src_select();
    do_reset();
    set_id(1, 4'd1, 4'd6, 1, 0, 4'd6, 0, 1); @(negedge clk);
    set_id(1, 4'd6, 4'd6, 1, 1, 4'd8, 0, 0); #1;
    checks++; if (ctl_nf !== C_NONE) begin failures++; $display("FAIL wb0_no_dep got=%b exp=%b", ctl_nf, C_NONE); end
    @(negedge clk);
    set_id(1, 4'd1, 4'd2, 1, 1, 4'd7, 0, 0); @(negedge clk);
    set_id(1, 4'd1, 4'd7, 0, 1, 4'd9, 0, 0); #1;
    checks++; if (ctl_nf !== C_NONE) begin failures++; $display("FAIL src2_unused got=%b exp=%b", ctl_nf, C_NONE); end
    @(negedge clk);
    set_id(1, 4'd1, 4'd7, 1, 1, 4'd9, 0, 0); #1;
    checks++; if (ctl_nf !== C_STALL) begin failures++; $display("FAIL src2_mem_hit got=%b exp=%b", ctl_nf, C_STALL); end
    @(negedge clk); idle(); @(negedge clk);
    set_id(1, 4'd1, 4'd2, 1, 1, 4'd0, 0, 0); @(negedge clk);
    set_id(1, 4'd0, 4'd5, 0, 1, 4'd5, 0, 0); #1;
    checks++; if (ctl_nf !== C_STALL) begin failures++; $display("FAIL r0_tracked got=%b exp=%b", ctl_nf, C_STALL); end
    @(negedge clk);
    set_id(0, 4'd0, 4'd5, 0, 1, 4'd5, 0, 0); #1;
    checks++; if (ctl_nf !== C_NONE) begin failures++; $display("FAIL invalid_no_hazard got=%b exp=%b", ctl_nf, C_NONE); end
    @(negedge clk);
  endtask

  task automatic test_branch();
    do_reset();
    set_id(1, 4'd1, 4'd0, 0, 1, 4'd2, 1, 0); @(negedge clk);
    set_id(1, 4'd2, 4'd2, 1, 1, 4'd4, 0, 0); branch_taken = 1'b1; #1;
    checks++; if (ctl_fw !== C_BR) begin failures++; $display("FAIL br_flush_fw got=%b exp=%b", ctl_fw, C_BR); end
    checks++; if (ctl_nf !== C_BR) begin failures++; $display("FAIL br_flush_nf got=%b exp=%b", ctl_nf, C_BR); end
    @(negedge clk); branch_taken = 1'b0; #1;
    checks++; if (ctl_fw !== C_NONE) begin failures++; $display("FAIL br_sb_ex_empty got=%b exp=%b", ctl_fw, C_NONE); end
    checks++; if (ctl_nf !== C_STALL) begin failures++; $display("FAIL br_nf_mem_dep got=%b exp=%b", ctl_nf, C_STALL); end
    @(negedge clk); idle(); @(negedge clk);
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_id(1, 4'd1, 4'd0, 0, 1, 4'd2, 1, 0); @(negedge clk);
    idle(); @(negedge clk);
    mem_ready = 1'b0; branch_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (ctl_fw !== C_HOLD) begin failures++; $display("FAIL mw_hold_%0d got=%b exp=%b", i, ctl_fw, C_HOLD); end
      @(negedge clk);
    end
    mem_ready = 1'b1; #1;
    checks++; if (ctl_fw !== C_BR) begin failures++; $display("FAIL mw_release_flush got=%b exp=%b", ctl_fw, C_BR); end
    @(negedge clk); branch_taken = 1'b0; #1;
    checks++; if (if_fw.stall_cnt !== 16'd5) begin failures++; $display("FAIL mw_stall_cnt got=%0d exp=5", if_fw.stall_cnt); end
    checks++; if (if_fw.mem_timeout !== 1'b0) begin failures++; $display("FAIL mw_no_timeout got=%b exp=0", if_fw.mem_timeout); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic exp_to;
    do_reset();
    set_id(1, 4'd2, 4'd0, 0, 1, 4'd1, 1, 0); @(negedge clk);
    idle(); @(negedge clk);
    mem_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      exp_to = (k >= 5);
      #1;
      checks++; if (ctl_nf !== C_HOLD) begin failures++; $display("FAIL to_hold_%0d got=%b exp=%b", k, ctl_nf, C_HOLD); end
      checks++; if (if_nf.mem_timeout !== exp_to) begin failures++; $display("FAIL to_flag_%0d got=%b exp=%b", k, if_nf.mem_timeout, exp_to); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (if_nf.mem_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky_%0d got=%b exp=1", k, if_nf.mem_timeout); end
      checks++; if (ctl_nf !== C_NONE) begin failures++; $display("FAIL to_run_%0d got=%b exp=%b", k, ctl_nf, C_NONE); end
      @(negedge clk);
    end
    #1;
    checks++; if (if_nf.stall_cnt !== 16'd10) begin failures++; $display("FAIL to_stall_cnt got=%0d exp=10", if_nf.stall_cnt); end
    rst = 1'b0; #1;
    checks++; if (if_nf.mem_timeout !== 1'b0) begin failures++; $display("FAIL to_clear_on_rst got=%b exp=0", if_nf.mem_timeout); end
    @(negedge clk); rst = 1'b1; @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1, 4'd2, 4'd0, 0, 1, 4'd1, 1, 0); @(negedge clk);
    idle(); @(negedge clk);
    mem_ready = 1'b0; #1;
    checks++; if (ctl_nf !== C_HOLD) begin failures++; $display("FAIL rms_hold got=%b exp=%b", ctl_nf, C_HOLD); end
    @(negedge clk); #1;
    rst = 1'b0; #1;
    checks++; if (ctl_nf !== C_NONE) begin failures++; $display("FAIL rms_ctl_nf got=%b exp=%b", ctl_nf, C_NONE); end
    checks++; if (ctl_fw !== C_NONE) begin failures++; $display("FAIL rms_ctl_fw got=%b exp=%b", ctl_fw, C_NONE); end
    checks++; if (if_nf.stall_cnt !== 16'd0) begin failures++; $display("FAIL rms_stall_cnt got=%0d exp=0", if_nf.stall_cnt); end
    @(negedge clk); rst = 1'b1;
    set_id(1, 4'd1, 4'd1, 1, 1, 4'd2, 0, 0); #1;
    checks++; if (ctl_nf !== C_NONE) begin failures++; $display("FAIL rms_after_release got=%b exp=%b", ctl_nf, C_NONE); end
    @(negedge clk); idle(); #1;
    checks++; if (if_nf.stall_cnt !== 16'd0) begin failures++; $display("FAIL rms_no_stall got=%0d exp=0", if_nf.stall_cnt); end
    mem_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; idle(); branch_taken = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_raw_stall();
    test_load_use_fw();
    test_src_select();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
